// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - E-stage operand/result bundle for the iterative multiply/divide unit
interface mul_div_unit_if;
  logic [4:0]  alucontrol;
  logic        start;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_o;
  logic        ready_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport master (
    output alucontrol, start, flush, a, b,
    input  stall_o, ready_o, hi_o, lo_o
  );

  modport slave (
    input  alucontrol, start, flush, a, b,
    output stall_o, ready_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative shift-add multiplier / restoring divider owning HI/LO
// Magnitudes are processed unsigned; sign correction is applied once in FIX.
module mul_div_unit #(
  parameter int ITER = 32
) (
  input logic          clk,
  input logic          rst,
  mul_div_unit_if.slave md
);
  localparam logic [4:0] ALU_SIGNED_MULT   = 5'd12;
  localparam logic [4:0] ALU_UNSIGNED_MULT = 5'd13;
  localparam logic [4:0] ALU_SIGNED_DIV    = 5'd14;
  localparam logic [4:0] ALU_UNSIGNED_DIV  = 5'd15;
  localparam logic [4:0] ALU_MTHI          = 5'd16;
  localparam logic [4:0] ALU_MTLO          = 5'd17;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          op_div, op_signed, sign_a, sign_b;
  logic [31:0]   divisor;
  logic [63:0]   acc;
  logic [32:0]   rem;
  logic [31:0]   hi, lo;
  logic          ready;

  logic          live, is_mult, is_div, is_signed, is_md, div_zero;
  logic [31:0]   mag_a, mag_b;
  logic [32:0]   mult_sum;
  logic [33:0]   shifted;
  logic [32:0]   diff;
  logic          ge;
  logic [63:0]   prod_fix;
  logic [31:0]   quot_fix, rem_fix;

  always_comb begin
    live      = md.start & ~md.flush;
    is_mult   = (md.alucontrol == ALU_SIGNED_MULT) | (md.alucontrol == ALU_UNSIGNED_MULT);
    is_div    = (md.alucontrol == ALU_SIGNED_DIV) | (md.alucontrol == ALU_UNSIGNED_DIV);
    is_signed = (md.alucontrol == ALU_SIGNED_MULT) | (md.alucontrol == ALU_SIGNED_DIV);
    is_md     = live & (is_mult | is_div);
    div_zero  = is_div & (md.b == 32'd0);
    mag_a     = (is_signed & md.a[31]) ? -md.a : md.a;
    mag_b     = (is_signed & md.b[31]) ? -md.b : md.b;

    // acc[31:0] holds the multiplier (mult) or the dividend being shifted out (div)
    mult_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, divisor} : 33'd0);
    shifted   = {rem, acc[31]};
    ge        = shifted >= {2'b00, divisor};
    diff      = shifted[32:0] - {1'b0, divisor};

    prod_fix  = (op_signed & (sign_a ^ sign_b)) ? -acc : acc;
    quot_fix  = (op_signed & (sign_a ^ sign_b)) ? -acc[31:0] : acc[31:0];
    rem_fix   = (op_signed & sign_a) ? -rem[31:0] : rem[31:0];
  end

  // rst gates stall so the pipeline is released the instant reset lands
  assign md.stall_o = ~rst & ~md.flush &
                      (((state == IDLE) & is_md & ~div_zero) | (state == CALC) | (state == FIX));
  assign md.ready_o = ready;
  assign md.hi_o    = hi;
  assign md.lo_o    = lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      divisor   <= 32'd0;
      acc       <= 64'd0;
      rem       <= 33'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      ready     <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (md.flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (is_md) begin
              if (div_zero) begin
                state <= DONE;
                ready <= 1'b1;
              end else begin
                op_div    <= is_div;
                op_signed <= is_signed;
                sign_a    <= is_signed & md.a[31];
                sign_b    <= is_signed & md.b[31];
                acc       <= {32'd0, mag_a};
                divisor   <= mag_b;
                rem       <= 33'd0;
                count     <= '0;
                state     <= CALC;
              end
            end else if (live & (md.alucontrol == ALU_MTHI)) begin
              hi <= md.a;
            end else if (live & (md.alucontrol == ALU_MTLO)) begin
              lo <= md.a;
            end
          end
          CALC: begin
            if (op_div) begin
              rem        <= ge ? diff : shifted[32:0];
              acc[31:0]  <= {acc[30:0], ge};
            end else begin
              acc <= {mult_sum, acc[31:1]};
            end
            count <= count + 1'b1;
            if (count == CW'(ITER - 1)) state <= FIX;
          end
          FIX: begin
            if (op_div) begin
              lo <= quot_fix;
              hi <= rem_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
            state <= DONE;
            ready <= 1'b1;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit
module tb_mul_div_unit;
  localparam logic [4:0] NOP  = 5'd0;
  localparam logic [4:0] SM   = 5'd12;
  localparam logic [4:0] UM   = 5'd13;
  localparam logic [4:0] SD   = 5'd14;
  localparam logic [4:0] UD   = 5'd15;
  localparam logic [4:0] MTHI = 5'd16;
  localparam logic [4:0] MTLO = 5'd17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   errors = 0;

  mul_div_unit_if bus();

  mul_div_unit #(.ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; holds start through DONE like a stalled E stage.
  task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                        output int stalls, output int rdy_at);
    stalls = 0;
    rdy_at = -1;
    bus.alucontrol = op;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    bus.flush = 1'b0;
    for (int cyc = 0; cyc < 80 && rdy_at < 0; cyc++) begin
      #1;
      if (bus.stall_o) stalls++;
      if (bus.ready_o) rdy_at = cyc;
      next_cycle();
    end
    bus.start = 1'b0;
    bus.alucontrol = NOP;
    if (rdy_at < 0) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue_move(input logic [4:0] op, input logic [31:0] av);
    bus.alucontrol = op;
    bus.a = av;
    bus.start = 1'b1;
    #1;
    check("move_no_stall", {63'd0, bus.stall_o}, 64'd0);
    next_cycle();
    bus.start = 1'b0;
    bus.alucontrol = NOP;
  endtask

  int stalls, rdy_at, ready_seen;

  initial begin
    bus.alucontrol = NOP;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    #2;
    check("rst_hi", {32'd0, bus.hi_o}, 64'd0);
    check("rst_lo", {32'd0, bus.lo_o}, 64'd0);
    check("rst_stall", {63'd0, bus.stall_o}, 64'd0);
    check("rst_ready", {63'd0, bus.ready_o}, 64'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_op(UM, 32'hFFFFFFFF, 32'hFFFFFFFF, stalls, rdy_at);
    check("umul_hi", {32'd0, bus.hi_o}, 64'hFFFFFFFE);
    check("umul_lo", {32'd0, bus.lo_o}, 64'h00000001);
    check("umul_stalls", 64'(stalls), 64'd34);
    check("umul_ready_at", 64'(rdy_at), 64'd34);
    #1;
    check("umul_ready_once", {63'd0, bus.ready_o}, 64'd0);
    next_cycle();

    run_op(SM, 32'hFFFFFFFD, 32'd5, stalls, rdy_at);
    check("smul_hi", {32'd0, bus.hi_o}, 64'hFFFFFFFF);
    check("smul_lo", {32'd0, bus.lo_o}, 64'hFFFFFFF1);

    run_op(SD, 32'hFFFFFFF9, 32'd2, stalls, rdy_at);
    check("sdiv_lo", {32'd0, bus.lo_o}, 64'hFFFFFFFD);
    check("sdiv_hi", {32'd0, bus.hi_o}, 64'hFFFFFFFF);
    check("sdiv_stalls", 64'(stalls), 64'd34);

    run_op(UD, 32'hFFFFFFF9, 32'd2, stalls, rdy_at);
    check("udiv_lo", {32'd0, bus.lo_o}, 64'h7FFFFFFC);
    check("udiv_hi", {32'd0, bus.hi_o}, 64'h00000001);

    run_op(SD, 32'h80000000, 32'hFFFFFFFF, stalls, rdy_at);
    check("sdiv_ovf_lo", {32'd0, bus.lo_o}, 64'h80000000);
    check("sdiv_ovf_hi", {32'd0, bus.hi_o}, 64'h00000000);

    issue_move(MTHI, 32'h11);
    issue_move(MTLO, 32'h22);
    check("mthi_pre", {32'd0, bus.hi_o}, 64'h11);
    check("mtlo_pre", {32'd0, bus.lo_o}, 64'h22);

    run_op(UD, 32'd5, 32'd0, stalls, rdy_at);
    check("dz_stalls", 64'(stalls), 64'd0);
    check("dz_ready_at", 64'(rdy_at), 64'd1);
    check("dz_hi", {32'd0, bus.hi_o}, 64'h11);
    check("dz_lo", {32'd0, bus.lo_o}, 64'h22);

    // flush at T+10 while in CALC
    bus.alucontrol = UM;
    bus.a = 32'd3;
    bus.b = 32'd4;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) next_cycle();
    bus.flush = 1'b1;
    #1;
    check("flush_stall", {63'd0, bus.stall_o}, 64'd0);
    next_cycle();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.alucontrol = NOP;
    #1;
    check("post_flush_stall", {63'd0, bus.stall_o}, 64'd0);
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ready_o) ready_seen++;
      next_cycle();
    end
    check("flush_no_ready", 64'(ready_seen), 64'd0);
    check("flush_hi", {32'd0, bus.hi_o}, 64'h11);
    check("flush_lo", {32'd0, bus.lo_o}, 64'h22);

    // hold-over: MTHI issued right after DONE must not see a restarted unit
    run_op(UM, 32'd6, 32'd7, stalls, rdy_at);
    check("mul42_lo", {32'd0, bus.lo_o}, 64'd42);
    check("mul42_hi", {32'd0, bus.hi_o}, 64'd0);
    bus.alucontrol = MTHI;
    bus.a = 32'h12345678;
    bus.start = 1'b1;
    #1;
    check("holdover_stall", {63'd0, bus.stall_o}, 64'd0);
    check("holdover_ready", {63'd0, bus.ready_o}, 64'd0);
    next_cycle();
    bus.start = 1'b0;
    bus.alucontrol = NOP;
    #1;
    check("holdover_hi", {32'd0, bus.hi_o}, 64'h12345678);
    check("holdover_idle", {63'd0, bus.stall_o}, 64'd0);
    next_cycle();

    // reset asserted at T+15 of a mult
    bus.alucontrol = UM;
    bus.a = 32'd7;
    bus.b = 32'd9;
    bus.start = 1'b1;
    for (int i = 0; i < 15; i++) next_cycle();
    #1;
    check("calc_stall", {63'd0, bus.stall_o}, 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_stall", {63'd0, bus.stall_o}, 64'd0);
    check("midrst_hi", {32'd0, bus.hi_o}, 64'd0);
    check("midrst_lo", {32'd0, bus.lo_o}, 64'd0);
    bus.start = 1'b0;
    bus.alucontrol = NOP;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    run_op(UM, 32'h00010000, 32'h00010001, stalls, rdy_at);
    check("postrst_hi", {32'd0, bus.hi_o}, 64'h00000001);
    check("postrst_lo", {32'd0, bus.lo_o}, 64'h00010000);
    check("postrst_ready_at", 64'(rdy_at), 64'd34);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit in the execute stage, driven by the 5-bit `alucontrol` produced by the ALU decoder. It executes `ALU_SIGNED_MULT`, `ALU_UNSIGNED_MULT`, `ALU_SIGNED_DIV` and `ALU_UNSIGNED_DIV` over multiple cycles and owns the HI/LO architectural registers, which `ALU_MTHI`/`ALU_MTLO` also write. While an operation is in flight it stalls the pipeline, then releases the pipeline for exactly one completion cycle.

## Interface
- `ITER`, 32, iteration cycles per mult/div; one operand bit per cycle.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alucontrol` in 5: operation code, using the `aludefines.vh` macros.
- `start` in 1: E-stage instruction valid, not bubbled.
- `flush` in 1: cancels the E-stage instruction (exception or redirect).
- `a` in 32: rs operand.
- `b` in 32: rt operand.
- `stall_o` out 1: pipeline must hold the E stage.
- `ready_o` out 1: one-cycle pulse when a mult/div finishes.
- `hi_o` out 32: HI register.
- `lo_o` out 32: LO register.

## Operation
- `is_md` = `start` & !`flush` & `alucontrol` ∈ {SIGNED/UNSIGNED MULT/DIV}.
- FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - If `is_md` and `b`≠0, or the op is a mult: latch |a|, |b| (magnitudes only for signed ops), sign_a, sign_b and op; count←0; go to CALC.
  - Div with `b`==0: go directly to DONE. HI/LO are unchanged.
  - `start` & !`flush` & `ALU_MTHI`: hi←a at this edge. No stall. Stays in IDLE.
  - `start` & !`flush` & `ALU_MTLO`: lo←a at this edge. No stall. Stays in IDLE.
  - Any other op: no action.
- **CALC** (mult): shift-add on a 64-bit accumulator, one multiplier bit per cycle.
- **CALC** (div): restoring division. 33-bit partial remainder; one quotient bit per cycle.
- CALC ends when count==ITER-1; next state is FIX.
- **FIX**: apply sign correction, then write HI/LO.
  - Signed mult: negate the 64-bit product (two's complement) if sign_a^sign_b.
  - Signed div: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Mult result: HI←prod[63:32], LO←prod[31:0].
  - Div result: LO←quotient, HI←remainder.
  - Next state: DONE.
- **DONE**: `ready_o`=1. `start` is ignored, because the same instruction is still in E. Next state: IDLE.
- **flush** in any state:
  - Next state is IDLE; the in-flight result is discarded.
  - HI/LO keep their old values.
  - A flush in FIX suppresses the HI/LO write.
- Arithmetic is modulo 2^32 / 2^64. Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- Signed div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.

## Timing
- Reset values: state=IDLE; hi=lo=0; count=0; `stall_o`=0; `ready_o`=0.
- `stall_o` is combinational:
  - (IDLE & `is_md` & !div-by-zero) | CALC | FIX, all gated by !`flush`.
  - `stall_o` is 0 in DONE.
- Accept in cycle T:
  - CALC runs T+1..T+ITER.
  - FIX is at T+ITER+1.
  - DONE is at T+ITER+2, with new HI/LO visible.
  - `stall_o` is high T..T+ITER+1: 34 cycles at ITER=32.
- Div-by-zero: `stall_o` is 0; DONE is at T+1.
- MTHI/MTLO: HI/LO update at the end of the issuing cycle and are visible at T+1.
- `ready_o` is registered, 1 only in DONE.
- `hi_o`/`lo_o` are registered, direct from HI/LO.
- Reset asserted mid-operation: immediately return to IDLE and clear HI/LO to 0, with `stall_o`=0 asynchronously.

## Test plan
- **Unsigned mult 0xFFFFFFFF×0xFFFFFFFF** -> HI=0xFFFFFFFE, LO=0x00000001 at T+34. `stall_o` high for exactly 34 cycles. `ready_o` pulses once.
- **Signed mult** a=0xFFFFFFFD (−3), b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- **Signed div** −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- **Unsigned div** 0xFFFFFFF9/2 -> LO=0x7FFFFFFC, HI=0x00000001.
- **Div by zero** a=5, b=0 with HI/LO preloaded 0x11/0x22 -> HI/LO unchanged. `stall_o` never high; `ready_o` at T+1.
- **Flush and hold-over**
  - Flush at T+10 -> IDLE next cycle; HI/LO unchanged; `stall_o` 0 in the flush cycle.
  - `start` held through DONE does not restart the unit.
  - MTHI a=0x12345678 immediately after DONE -> `hi_o`=0x12345678 one cycle later with no stall.
- **Reset mid-CALC** (T+15) -> `stall_o` drops asynchronously; HI=LO=0; a new mult after reset completes with the correct result in 34 cycles.
